// File: rtl/uart_rx_byte.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_byte
// Purpose  : UART receiver. Turns an 8N1 serial stream (8E1 when
//            UART_RX_PARITY_EN is defined) into bytes, each one flagged by a
//            single-cycle rx_rdy strobe.
// Ports    : clk        in   system clock
//            rst_n      in   asynchronous active-low reset
//            RX         in   asynchronous serial line, idle high
//            rx_data    out  last correctly received byte, held until the
//                            next good frame
//            rx_rdy     out  one-cycle pulse when rx_data is updated
//            frame_err  out  one-cycle pulse when the stop bit is sampled low
//            parity_err out  (UART_RX_PARITY_EN only) one-cycle pulse on a
//                            parity mismatch with a good stop bit
//            busy       out  high whenever the receiver is not idle
// Params   : CLKS_PER_BIT  clk cycles per bit, 4 or more
// Macro    : UART_RX_PARITY_EN  enables the even-parity bit and parity_err
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // The counter expires when it reaches zero, so loading K-1 gives the
  // decision on the K-th cycle after the load.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  logic          sync1;
  logic          rx_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          expire;
  logic          load_half;
  logic          load_full;
  logic          shift_en;
  logic          clr_bits;
  logic          accept;
  logic          ferr_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          par_cap;
  logic          par_bad;
  logic          perr_set;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = ^{shreg, par_bit};
`endif

  assign expire = (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_nxt = ST_START;
      ST_START: if (expire) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (expire && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
        state_nxt = ST_PARITY;
`else
        state_nxt = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (expire) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (expire) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
      // A line stuck low is swallowed here so it cannot retrigger frames.
      ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    busy      = (state != ST_IDLE);
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    accept    = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap   = 1'b0;
    perr_set  = 1'b0;
`endif
    case (state)
      ST_IDLE:  load_half = !rx_s;
      ST_START: if (expire && !rx_s) begin
        load_full = 1'b1;
        clr_bits  = 1'b1;
      end
      ST_DATA:  if (expire) begin
        shift_en  = 1'b1;
        load_full = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (expire) begin
        par_cap   = 1'b1;
        load_full = 1'b1;
      end
`endif
      ST_STOP:  if (expire) begin
        // A low stop bit wins over any parity result.
        if (!rx_s)        ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (par_bad) perr_set = 1'b1;
`endif
        else              accept   = 1'b1;
      end
      default: ;
    endcase
  end

  // Synchronizer, counters, shift register and registered outputs. The
  // synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      rx_data    <= 8'h00;
      rx_rdy     <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1 <= RX;
      rx_s  <= sync1;

      if (load_half)      cnt <= HALF_LOAD;
      else if (load_full) cnt <= FULL_LOAD;
      else if (!expire)   cnt <= cnt - CNT_ONE;

      if (clr_bits)      bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

      // Line order is LSB first, so each new bit enters at the MSB.
      if (shift_en) shreg <= {rx_s, shreg[7:1]};

      if (accept) rx_data <= shreg;
      rx_rdy    <= accept;
      frame_err <= ferr_set;
`ifdef UART_RX_PARITY_EN
      if (par_cap) par_bit <= rx_s;
      parity_err <= perr_set;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_byte
// Purpose  : Directed self-checking bench for uart_rx_byte at CLKS_PER_BIT=16.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int vec_n;
  int miss_n;
  int cyc;

  // Observations collected by the monitor
  logic [7:0] rdy_q[$];
  int         rdy_t[$];
  int         ferr_n;
  int         ferr_t;
  int         both_n;
  int         perr_n;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_rdy) begin
      rdy_q.push_back(rx_data);
      rdy_t.push_back(cyc);
    end
    if (frame_err) begin
      ferr_n = ferr_n + 1;
      ferr_t = cyc;
    end
    if (rx_rdy && frame_err) both_n = both_n + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_n = perr_n + 1;
`endif
  end

  task automatic clear_obs();
    rdy_q.delete();
    rdy_t.delete();
    ferr_n = 0;
    ferr_t = -1;
    both_n = 0;
    perr_n = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (call at posedge+1). st = cycle of the
  // start-bit falling edge. Ends aligned for an immediate next frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic use_par, input logic par_v,
                            output int st);
    st = cyc;
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_cycles(CPB);
    end
    if (use_par) begin
      RX = par_v;
      wait_cycles(CPB);
    end
    RX = stop_v;
    wait_cycles(CPB);
  endtask

  task automatic test_reset();
    RX    = 1'b1;
    rst_n = 1'b0;
    wait_cycles(3);
    vec_n++; if (rx_data !== 8'h00) begin miss_n++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    vec_n++; if (rx_rdy !== 1'b0) begin miss_n++; $display("FAIL reset_rx_rdy: got %b expected 0", rx_rdy); end
    vec_n++; if (frame_err !== 1'b0) begin miss_n++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    clear_obs();
    wait_cycles(20);
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL release_busy: got %b expected 0", busy); end
    vec_n++; if (rdy_q.size() !== 0) begin miss_n++; $display("FAIL release_no_rdy: got %0d pulses expected 0", rdy_q.size()); end
  endtask

  task automatic test_single_byte();
    int st;
    clear_obs();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, st);
    wait_cycles(10);
    vec_n++; if (rdy_q.size() !== 1) begin miss_n++; $display("FAIL a5_pulse_count: got %0d expected 1", rdy_q.size()); end
    if (rdy_q.size() > 0) begin
      vec_n++; if (rdy_t[0] - st !== 155) begin miss_n++; $display("FAIL a5_latency: got %0d expected 155", rdy_t[0] - st); end
      vec_n++; if (rdy_q[0] !== 8'hA5) begin miss_n++; $display("FAIL a5_strobe_data: got %h expected a5", rdy_q[0]); end
    end
    vec_n++; if (rx_data !== 8'hA5) begin miss_n++; $display("FAIL a5_rx_data: got %h expected a5", rx_data); end
    vec_n++; if (ferr_n !== 0) begin miss_n++; $display("FAIL a5_frame_err: got %0d expected 0", ferr_n); end
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL a5_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int st0;
    int st;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
    clear_obs();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, st0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, st);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, st);
    wait_cycles(10);
    vec_n++; if (rdy_q.size() !== 3) begin miss_n++; $display("FAIL b2b_pulse_count: got %0d expected 3", rdy_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < rdy_q.size()) begin
        vec_n++; if (rdy_q[i] !== exp_d[i]) begin miss_n++; $display("FAIL b2b_data%0d: got %h expected %h", i, rdy_q[i], exp_d[i]); end
        vec_n++; if (rdy_t[i] - st0 !== 155 + 160 * i) begin miss_n++; $display("FAIL b2b_time%0d: got %0d expected %0d", i, rdy_t[i] - st0, 155 + 160 * i); end
      end
    end
    vec_n++; if (both_n !== 0) begin miss_n++; $display("FAIL b2b_exclusive: got %0d overlaps expected 0", both_n); end
  endtask

  task automatic test_glitch();
    clear_obs();
    RX = 1'b0;
    wait_cycles(4);
    RX = 1'b1;
    vec_n++; if (busy !== 1'b1) begin miss_n++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    wait_cycles(7);
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL glitch_busy_release: got %b expected 0", busy); end
    wait_cycles(200);
    vec_n++; if (rdy_q.size() !== 0) begin miss_n++; $display("FAIL glitch_no_rdy: got %0d expected 0", rdy_q.size()); end
    vec_n++; if (ferr_n !== 0) begin miss_n++; $display("FAIL glitch_no_ferr: got %0d expected 0", ferr_n); end
  endtask

  task automatic test_frame_error();
    int st;
    clear_obs();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, st);
    wait_cycles(300);
    vec_n++; if (busy !== 1'b1) begin miss_n++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
    wait_cycles(200);
    RX = 1'b1;
    wait_cycles(20);
    vec_n++; if (ferr_n !== 1) begin miss_n++; $display("FAIL ferr_count: got %0d expected 1", ferr_n); end
    vec_n++; if (ferr_t - st !== 155) begin miss_n++; $display("FAIL ferr_time: got %0d expected 155", ferr_t - st); end
    vec_n++; if (rdy_q.size() !== 0) begin miss_n++; $display("FAIL ferr_no_rdy: got %0d expected 0", rdy_q.size()); end
    vec_n++; if (rx_data !== 8'h3C) begin miss_n++; $display("FAIL ferr_rx_data_held: got %h expected 3c", rx_data); end
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL ferr_busy_after: got %b expected 0", busy); end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, st);
    wait_cycles(10);
    vec_n++; if (rdy_q.size() !== 1) begin miss_n++; $display("FAIL ferr_recover_count: got %0d expected 1", rdy_q.size()); end
    vec_n++; if (rx_data !== 8'h5A) begin miss_n++; $display("FAIL ferr_recover_data: got %h expected 5a", rx_data); end
    vec_n++; if (ferr_n !== 1) begin miss_n++; $display("FAIL ferr_no_more: got %0d expected 1", ferr_n); end
  endtask

  task automatic test_reset_midframe();
    int st;
    logic [7:0] d;
    d = 8'h77;
    clear_obs();
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      RX = d[i];
      wait_cycles(CPB);
    end
    RX = d[4];
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    wait_cycles(1);
    vec_n++; if (rx_data !== 8'h00) begin miss_n++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    vec_n++; if (busy !== 1'b0) begin miss_n++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vec_n++; if ({rx_rdy, frame_err} !== 2'b00) begin miss_n++; $display("FAIL midrst_strobes: got %b expected 00", {rx_rdy, frame_err}); end
    RX = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(50);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, st);
    wait_cycles(10);
    vec_n++; if (rdy_q.size() !== 1) begin miss_n++; $display("FAIL midrst_pulse_count: got %0d expected 1", rdy_q.size()); end
    if (rdy_q.size() > 0) begin
      vec_n++; if (rdy_q[0] !== 8'h12) begin miss_n++; $display("FAIL midrst_data: got %h expected 12", rdy_q[0]); end
    end
    vec_n++; if (ferr_n !== 0) begin miss_n++; $display("FAIL midrst_no_ferr: got %0d expected 0", ferr_n); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int st;
    clear_obs();
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, st);
    wait_cycles(10);
    vec_n++; if (rdy_q.size() !== 1) begin miss_n++; $display("FAIL par0_count: got %0d expected 1", rdy_q.size()); end
    vec_n++; if (rx_data !== 8'h81) begin miss_n++; $display("FAIL par0_data: got %h expected 81", rx_data); end
    vec_n++; if (perr_n !== 0) begin miss_n++; $display("FAIL par0_perr: got %0d expected 0", perr_n); end
    clear_obs();
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, st);
    wait_cycles(10);
    vec_n++; if (perr_n !== 1) begin miss_n++; $display("FAIL par1_perr: got %0d expected 1", perr_n); end
    vec_n++; if (rdy_q.size() !== 0) begin miss_n++; $display("FAIL par1_no_rdy: got %0d expected 0", rdy_q.size()); end
    vec_n++; if (rx_data !== 8'h81) begin miss_n++; $display("FAIL par1_data_held: got %h expected 81", rx_data); end
    vec_n++; if (ferr_n !== 0) begin miss_n++; $display("FAIL par1_no_ferr: got %0d expected 0", ferr_n); end
  endtask
`endif

  initial begin
    vec_n  = 0;
    miss_n = 0;
    RX     = 1'b1;
    rst_n  = 1'b0;
    clear_obs();
    wait_cycles(2);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

`default_nettype wire
